// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement add/sub, DIGIT bits/cycle; ADDSUB_SAT_EN clamps signed overflow.
// Latency NDIG cycles from accept; result held in DONE until out_ready, no accept in the result-handshake cycle.
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             v
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("add_sub_serial: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, carry_q, v_q, in_ready_q, out_valid_q;

    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   dres;
    logic             dv;
    int               sh;

    // One digit slice per cycle; carry into the slice MSB is recovered as a^b^s of that bit.
    always_comb begin
        sh    = DIGIT * int'(cnt_q);
        a_sl  = DIGIT'(a_q >> sh);
        b_sl  = DIGIT'(b_q >> sh);
        dres  = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, c_q};
        dv    = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ dres[DIGIT-1] ^ dres[DIGIT];
        sum_d = (sum_q & ~(DMASK << sh)) | (WIDTH'(dres[DIGIT-1:0]) << sh);
`ifdef ADDSUB_SAT_EN
        if (cnt_q == LAST && dv) begin
            sum_d = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            carry_q     <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{m}};
                        c_q        <= m;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q <= sum_d;
                    c_q   <= dres[DIGIT];
                    if (cnt_q == LAST) begin
                        carry_q     <= dres[DIGIT];
                        v_q         <= dv;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign v         = v_q;
endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: DIGIT=4 (NDIG=4) and DIGIT=16 (NDIG=1) instances side by side.
// Inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_add_sub_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sel, m, out_ready;
    logic [15:0] a, b;

    logic        in_valid0, in_ready0, out_valid0, carry0, v0;
    logic        in_valid1, in_ready1, out_valid1, carry1, v1;
    logic [15:0] sum0, sum1;
    logic        o_in_ready, o_out_valid, o_carry, o_v;
    logic [15:0] o_sum;

    int checks = 0;
    int errors = 0;

`ifdef ADDSUB_SAT_EN
    localparam logic [15:0] POS_OVF = 16'h7FFF;
    localparam logic [15:0] NEG_OVF = 16'h8000;
`else
    localparam logic [15:0] POS_OVF = 16'h8000;
    localparam logic [15:0] NEG_OVF = 16'h7FFF;
`endif

    always #5 clk = ~clk;

    assign in_valid0   = in_valid & ~sel;
    assign in_valid1   = in_valid & sel;
    assign o_in_ready  = sel ? in_ready1  : in_ready0;
    assign o_out_valid = sel ? out_valid1 : out_valid0;
    assign o_sum       = sel ? sum1       : sum0;
    assign o_carry     = sel ? carry1     : carry0;
    assign o_v         = sel ? v1         : v0;

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .m(m), .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .carry(carry0), .v(v0)
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .m(m), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .carry(carry1), .v(v1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the selected instance: accept, latency, result, optional stall, handshake.
    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tm, input logic [15:0] es, input logic ec, input logic ev,
                       input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_rdy_idle"}, o_in_ready, 1);
        a = ta; b = tb_; m = tm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; m = ~tm;
        check({tag, "_rdy_busy"}, o_in_ready, 0);
        lat = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, sel ? 1 : 4);
        check({tag, "_sum"}, o_sum, es);
        check({tag, "_carry"}, o_carry, ec);
        check({tag, "_v"}, o_v, ev);
        check({tag, "_rdy_done"}, o_in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, o_out_valid, 1);
            check({tag, "_hold_sum"}, {o_sum, o_carry, o_v}, {es, ec, ev});
            check({tag, "_hold_rdy"}, o_in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, o_out_valid, 0);
        check({tag, "_rdy_back"}, o_in_ready, 1);
        check({tag, "_sum_kept"}, o_sum, es);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; m = 1'b0;
        #12;
        check("rst_rdy4", in_ready0, 1);
        check("rst_vld4", out_valid0, 0);
        check("rst_res4", {sum0, carry0, v0}, 0);
        check("rst_rdy16", in_ready1, 1);
        check("rst_res16", {out_valid1, sum1, carry1, v1}, 0);
        @(negedge clk); rst_n = 1'b1;

        run("add",     16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
        run("sub_brw", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
        run("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, POS_OVF,  1'b0, 1'b1, 0);
        run("neg_ovf", 16'h8000, 16'h0001, 1'b1, NEG_OVF,  1'b1, 1'b1, 0);
        run("bp",      16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 5);
        run("after_bp",16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        // Abort an operation after two digits have been written.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("mid_rst_vld", out_valid0, 0);
        check("mid_rst_sum", sum0, 0);
        check("mid_rst_rdy", in_ready0, 1);
        @(negedge clk); rst_n = 1'b1;
        run("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

        sel = 1'b1;
        run("d16_add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
        run("d16_pov", 16'h7FFF, 16'h0001, 1'b0, POS_OVF,  1'b0, 1'b1, 2);
        run("d16_nov", 16'h8000, 16'h0001, 1'b1, NEG_OVF,  1'b1, 1'b1, 0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #2; in_valid = 1'b0;
        rst_n = 1'b0; #1;
        check("d16_rst_vld", out_valid1, 0);
        check("d16_rst_sum", sum1, 0);
        check("d16_rst_rdy", in_ready1, 1);
        @(negedge clk); rst_n = 1'b1;
        run("d16_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_sub_serial.md
Name: add_sub_serial

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor. It is the multi-cycle successor of the team's 4-bit ripple adder-subtractor.
- Processes DIGIT bits per clock over a WIDTH-bit operand pair.
- Valid/ready handshakes on input and output, plus carry and signed-overflow flags.
- Sits in datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise); DIGIT = WIDTH gives single-digit operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b, m valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- m  in  1  mode: 0 = a+b, 1 = a−b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry  out  1  carry out of the MSB (subtract: 1 = no borrow, i.e. a ≥ b unsigned).
- v  out  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, sum=0, carry=0, v=0, state=IDLE, digit counter=0, internal carry=0.
- Derived constant: NDIG = WIDTH/DIGIT. The counter is sized to hold 0..NDIG−1.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at edge E0: capture a, capture (b XOR {WIDTH{m}}), set internal carry = m, set counter = 0, go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each edge adds the current DIGIT-bit slice of a, the slice of inverted-or-not b, and the internal carry, LSB digit first.
  - Writes the slice result into sum bits [k*DIGIT +: DIGIT] and updates the internal carry.
  - At the edge processing digit NDIG−1 (edge E_NDIG):
    - carry = carry out of bit WIDTH−1.
    - v = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
    - Go to DONE with out_valid=1.
  - Latency: out_valid is visible NDIG cycles after the accepting edge.
- State DONE:
  - out_valid=1, in_ready=0.
  - sum, carry and v are held stable until out_valid & out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid=0; the result registers keep their last values.
  - No new operand is accepted in the same cycle as the result handshake. Throughput is one op per NDIG+2 cycles when out_ready is held high.
- Input stability: inputs are ignored outside the IDLE handshake. Changing a/b/m during BUSY has no effect.
- Partial result: sum bits not yet written during BUSY are don't-care to observers. Only values qualified by out_valid are checked.
- Wrap-around: results are modulo 2^WIDTH. Example: 0xFFFF+0x0001 gives sum=0x0000, carry=1, v=0.
- Reset mid-operation: rst_n low in any state immediately forces the reset values and discards the operation in flight. After release, the first operation completes correctly.
- out_ready held high in IDLE/BUSY has no effect.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: on the final digit, if v would be 1, sum is clamped to the signed limit.
  - Positive overflow (sign of a = 0) gives 0111…1.
  - Negative overflow (sign of a = 1) gives 1000…0.
  - v is still reported as 1; carry is unchanged (raw).
  - Clamping happens at the same edge, so latency is unchanged.
- Undefined: sum is always the raw wrapped result.

Test Plan:
(WIDTH=16, DIGIT=4 unless noted)
1. Add, no overflow: accept a=0x1234, b=0x0FFF, m=0 → out_valid exactly 4 cycles after accept; sum=0x2233, carry=0, v=0. in_ready=0 from accept until the result handshake.
2. Subtract with borrow: a=0x0005, b=0x0007, m=1 → sum=0xFFFE, carry=0, v=0. Then a=0x0007, b=0x0005, m=1 → sum=0x0002, carry=1, v=0.
3. Positive overflow: a=0x7FFF, b=0x0001, m=0 → v=1, carry=0, sum=0x8000. With ADDSUB_SAT_EN, sum=0x7FFF.
4. Negative overflow via subtract: a=0x8000, b=0x0001, m=1 → v=1, carry=1, sum=0x7FFF. With ADDSUB_SAT_EN, sum=0x8000.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid → sum/carry/v/out_valid stable and in_ready=0. Raise out_ready → IDLE next cycle, in_ready=1, and the next op is accepted and correct.
6. Reset mid-BUSY: assert rst_n=0 after 2 digits → out_valid=0, sum=0, in_ready=1 asynchronously. After release, 0xFFFF+0x0001 → sum=0x0000, carry=1, v=0. Repeat with DIGIT=16 (NDIG=1): latency 1 cycle.
